// File: rtl/fir_frame_pkg.sv
// +----------------------------------------------------------------------------+
// | fir_frame_pkg                                                              |
// | Shared constants, bank-state type and frame flattening helper.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fir_frame_pkg;

    localparam int N     = 16;
    localparam int W     = 16;
    localparam int IDXW  = $clog2(N);
    localparam int FCNTW = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Bit offset of sample idx inside a flattened frame (index 0 at the LSBs).
    function automatic int frame_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_bank.sv
// +----------------------------------------------------------------------------+
// | frame_bank                                                                 |
// | N x W sample register file with indexed write and flat frame read port.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module frame_bank
    import fir_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDXW-1:0]   i_waddr,
    input  logic [W-1:0]      i_wdata,
    output logic [N*W-1:0]    o_frame
);

    logic [W-1:0] r_mem [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_flat
            assign o_frame[frame_lsb(g, W) +: W] = r_mem[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/fir_frame_buffer.sv
// +----------------------------------------------------------------------------+
// | fir_frame_buffer                                                           |
// | Ping-pong collector of FIR samples into N-sample frames for the FFT.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_frame_buffer
    import fir_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fir_valid,
    input  logic [W-1:0]      fir_d,
    input  logic              frm_ready,
    output logic              frm_valid,
    output logic [N*W-1:0]    frm_data,
    output logic [FCNTW-1:0]  frm_cnt,
    output logic              ovf
);

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(N - 1);

    bank_state_t             r_state     [2];
    bank_state_t             w_state_nxt [2];
    logic [N*W-1:0]          w_bank_frame [2];

    logic                    r_wsel;
    logic                    r_rsel;
    logic [IDXW-1:0]         r_widx;
    logic [FCNTW-1:0]        r_frm_cnt;
    logic                    r_ovf;

    logic                    w_wr_full;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_last;
    logic                    w_xfer;

    // Fullness is judged on the registered state, so a bank freed on this
    // same edge still blocks the incoming sample.
    assign w_wr_full = (r_state[r_wsel] == FULL);
    assign w_accept  = fir_valid && !w_wr_full;
    assign w_drop    = fir_valid && w_wr_full;
    assign w_last    = w_accept && (r_widx == c_last_idx);
    assign w_xfer    = frm_valid && frm_ready;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_bank
            frame_bank u_bank (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_we    (w_accept && (r_wsel == 1'(g))),
                .i_waddr (r_widx),
                .i_wdata (fir_d),
                .o_frame (w_bank_frame[g])
            );
        end
    endgenerate

    // Bank-state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    // Bank-state next-state logic; a write and a read never hit the same bank
    // on one edge because writes need a non-FULL bank and reads a FULL one.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_accept && (r_wsel == 1'(b))) begin
                w_state_nxt[b] = w_last ? FULL : FILLING;
            end
            if (w_xfer && (r_rsel == 1'(b))) begin
                w_state_nxt[b] = EMPTY;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        frm_valid = (r_state[r_rsel] == FULL);
        frm_data  = frm_valid ? w_bank_frame[r_rsel] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel    <= 1'b0;
            r_rsel    <= 1'b0;
            r_widx    <= '0;
            r_frm_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_widx <= w_last ? '0 : r_widx + 1'b1;
                if (w_last) begin
                    r_wsel <= ~r_wsel;
                end
            end
            if (w_xfer) begin
                r_rsel    <= ~r_rsel;
                r_frm_cnt <= r_frm_cnt + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign frm_cnt = r_frm_cnt;
    assign ovf     = r_ovf;

endmodule

`default_nettype wire
